// File: rtl/nes_bus_ram.sv
// Bus-attached NES RAM: region decode, power-of-two mirroring, programmable wait
// states with a one-cycle ready strobe, and an optional post-reset clear sweep.
module nes_bus_ram #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 16,
  parameter int                MEM_AW         = 11,
  parameter int                REGION_AW      = 13,
  parameter logic [ADDR_W-1:0] BASE           = 16'h0000,
  parameter int                WAIT_STATES    = 0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              rw_n,
  input  logic              cs_n,
  output logic              ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam bit                NO_WAIT     = (WAIT_STATES == 0);
  localparam logic [3:0]        WAIT_LOAD   = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [MEM_AW-1:0] CLR_LAST    = {MEM_AW{1'b1}};
  localparam logic [MEM_AW-1:0] CLR_STEP    = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [DATA_W-1:0] mem_r [0:(1<<MEM_AW)-1];

  state_t            state_r, state_nx;
  logic [MEM_AW-1:0] clr_cnt_r, clr_cnt_nx;
  logic [3:0]        wcnt_r, wcnt_nx;
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r;
  logic              busy_r;

  logic              hit_s;
  logic [MEM_AW-1:0] word_idx_s;
  logic              access_s;
  logic              clear_we_s;
  logic              mem_we_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic [DATA_W-1:0] mem_wd_s;
  logic              drive_s;

  assign hit_s      = !cs_n && (addr[ADDR_W-1:REGION_AW] == BASE[ADDR_W-1:REGION_AW]);
  assign word_idx_s = addr[MEM_AW-1:0];

  // Mirror bits are deliberately ignored so every alias maps onto the same word.
  if (REGION_AW > MEM_AW) begin : g_mirror
    logic unused_mirror_s;
    assign unused_mirror_s = ^addr[REGION_AW-1:MEM_AW];
  end

  // Next-state logic: clear sweep, wait-state countdown and access strobe.
  always_comb begin
    state_nx   = state_r;
    clr_cnt_nx = clr_cnt_r;
    wcnt_nx    = wcnt_r;
    access_s   = 1'b0;
    clear_we_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_we_s = 1'b1;
        clr_cnt_nx = clr_cnt_r + CLR_STEP;
        if (clr_cnt_r == CLR_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (hit_s && NO_WAIT) begin
          access_s = 1'b1;
          state_nx = ST_DONE;
        end else if (hit_s) begin
          wcnt_nx  = WAIT_LOAD;
          state_nx = ST_WAIT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!hit_s) begin
          state_nx = ST_IDLE;
        end else if (wcnt_r == 4'd0) begin
          access_s = 1'b1;
          state_nx = ST_DONE;
        end else begin
          wcnt_nx  = wcnt_r - 4'd1;
          state_nx = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = RESET_STATE;
      end
    endcase
  end

  // Memory write port: sweep writes take priority; nothing is written while in reset.
  always_comb begin
    mem_we_s  = 1'b0;
    mem_idx_s = word_idx_s;
    mem_wd_s  = data;
    if (clear_we_s) begin
      mem_we_s  = rst_n;
      mem_idx_s = clr_cnt_r;
      mem_wd_s  = CLEAR_VALUE;
    end else if (access_s && !rw_n) begin
      mem_we_s  = rst_n;
    end else begin
      mem_we_s  = 1'b0;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wd_s;
    end
  end

  // Control state, read data and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= {MEM_AW{1'b0}};
      wcnt_r    <= 4'd0;
      rdata_r   <= {DATA_W{1'b0}};
      ready_r   <= 1'b0;
      busy_r    <= CLEAR_ON_RESET;
    end else begin
      state_r   <= state_nx;
      clr_cnt_r <= clr_cnt_nx;
      wcnt_r    <= wcnt_nx;
      ready_r   <= (state_nx == ST_DONE);
      busy_r    <= (state_nx == ST_CLEAR);
      if (access_s && rw_n) begin
        rdata_r <= mem_r[word_idx_s];
      end
    end
  end

  assign drive_s = (state_r == ST_DONE) && hit_s && rw_n;
  assign data    = drive_s ? rdata_r : {DATA_W{1'bz}};
  assign ready   = ready_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_nes_bus_ram.sv
// Directed bench for nes_bus_ram: one instance with no wait states and a clear
// sweep, one with three wait states and no sweep; undriven buses pull up to 0xFF.
module tb_nes_bus_ram;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr0, addr3;
  logic        rw0, rw3;
  logic        cs0, cs3;
  logic [7:0]  wd0, wd3;
  logic        oe0, oe3;
  logic        ready0, ready3;
  logic        busy0, busy3;
  wire  [7:0]  data0, data3;

  int total;
  int bad;

  typedef struct {
    logic        dut3;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  wdata;
    logic        exp_ready;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [19];

  assign data0 = oe0 ? wd0 : 8'hzz;
  assign data3 = oe3 ? wd3 : 8'hzz;
  pullup (data0);
  pullup (data3);

  nes_bus_ram #(.WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) u_ram0 (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .data(data0),
    .rw_n(rw0), .cs_n(cs0), .ready(ready0), .busy(busy0)
  );

  nes_bus_ram #(.WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) u_ram3 (
    .clk(clk), .rst_n(rst_n), .addr(addr3), .data(data3),
    .rw_n(rw3), .cs_n(cs3), .ready(ready3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   ws;
    logic rdy;
    logic [7:0] bus;
    ws = v.dut3 ? 3 : 0;
    @(negedge clk);
    if (v.dut3) begin
      addr3 = v.addr; rw3 = v.rw_n; wd3 = v.wdata; oe3 = !v.rw_n; cs3 = 1'b0;
    end else begin
      addr0 = v.addr; rw0 = v.rw_n; wd0 = v.wdata; oe0 = !v.rw_n; cs0 = 1'b0;
    end
    for (int k = 1; k <= ws + 1; k++) begin
      @(posedge clk);
      #1;
      rdy = v.dut3 ? ready3 : ready0;
      bus = v.dut3 ? data3 : data0;
      if (k <= ws) begin
        chk($sformatf("v%0d_wait_ready", idx), {31'd0, rdy}, 32'd0);
      end else begin
        chk($sformatf("v%0d_ready", idx), {31'd0, rdy}, {31'd0, v.exp_ready});
        if (v.rw_n) begin
          chk($sformatf("v%0d_data", idx), {24'd0, bus},
              {24'd0, (v.exp_ready ? v.exp_data : 8'hFF)});
        end
      end
    end
    @(negedge clk);
    cs0 = 1'b1; oe0 = 1'b0; cs3 = 1'b1; oe3 = 1'b0;
    @(posedge clk);
    #1;
    rdy = v.dut3 ? ready3 : ready0;
    bus = v.dut3 ? data3 : data0;
    chk($sformatf("v%0d_after_ready", idx), {31'd0, rdy}, 32'd0);
    chk($sformatf("v%0d_after_data", idx), {24'd0, bus}, 32'hFF);
  endtask

  task automatic wait_sweep(input string nm);
    int n;
    n = 0;
    while (busy0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, 32'd2048);
  endtask

  initial begin
    int   n;
    logic stayed;
    vec_t v;
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 16'h07FF, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 16'h0123, 1'b0, 8'hA5, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 16'h0923, 1'b1, 8'h00, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 16'h1923, 1'b1, 8'h00, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 16'h0124, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 8'hC3, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 16'h2000, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 16'h2000, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'hC3};
    vecs[10] = '{1'b0, 16'h1800, 1'b1, 8'h00, 1'b1, 8'hC3};
    vecs[11] = '{1'b0, 16'hE123, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 16'h1FFF, 1'b0, 8'h3C, 1'b1, 8'h00};
    vecs[13] = '{1'b0, 16'h07FF, 1'b1, 8'h00, 1'b1, 8'h3C};
    vecs[14] = '{1'b1, 16'h0010, 1'b0, 8'h11, 1'b1, 8'h00};
    vecs[15] = '{1'b1, 16'h0810, 1'b1, 8'h00, 1'b1, 8'h11};
    vecs[16] = '{1'b1, 16'h0040, 1'b0, 8'h96, 1'b1, 8'h00};
    vecs[17] = '{1'b1, 16'h1040, 1'b1, 8'h00, 1'b1, 8'h96};
    vecs[18] = '{1'b1, 16'h2040, 1'b1, 8'h00, 1'b0, 8'h00};

    rst_n = 1'b0;
    addr0 = 16'h0000; rw0 = 1'b1; cs0 = 1'b1; wd0 = 8'h00; oe0 = 1'b0;
    addr3 = 16'h0000; rw3 = 1'b1; cs3 = 1'b1; wd3 = 8'h00; oe3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_ready3", {31'd0, ready3}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);

    // First sweep is interrupted by reset once index 1000 has been reached.
    @(negedge clk);
    rst_n = 1'b1;
    stayed = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (!busy0) stayed = 1'b0;
    end
    chk("sweep_busy_to_1000", {31'd0, stayed}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midsweep_rst_busy", {31'd0, busy0}, 32'd1);
    chk("midsweep_rst_ready", {31'd0, ready0}, 32'd0);

    // Restarted sweep, with a write to 0x0000 presented during its first cycles.
    @(negedge clk);
    rst_n = 1'b1;
    addr0 = 16'h0000; rw0 = 1'b0; wd0 = 8'hEE; oe0 = 1'b1; cs0 = 1'b0;
    n = 0;
    stayed = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (ready0) stayed = 1'b0;
    end
    chk("clear_ignores_req", {31'd0, stayed}, 32'd1);
    @(negedge clk);
    cs0 = 1'b1; oe0 = 1'b0; rw0 = 1'b1;
    while (busy0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sweep_len_restart", n, 32'd2048);

    for (int i = 0; i < 19; i++) begin
      run_vec(i, vecs[i]);
    end

    // Held read on the 3-wait instance: ready every 5 cycles, 4 after the request.
    @(negedge clk);
    addr3 = 16'h0040; rw3 = 1'b1; oe3 = 1'b0; cs3 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_ready_%0d", k), {31'd0, ready3}, {31'd0, (k % 5 == 4)});
      chk($sformatf("held_data_%0d", k), {24'd0, data3}, ((k % 5 == 4) ? 32'h96 : 32'hFF));
    end
    @(negedge clk);
    cs3 = 1'b1;
    @(posedge clk);

    // Write aborted by dropping cs_n in the second wait cycle.
    @(negedge clk);
    addr3 = 16'h0010; rw3 = 1'b0; wd3 = 8'h77; oe3 = 1'b1; cs3 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("abort_wait_ready", {31'd0, ready3}, 32'd0);
    end
    @(negedge clk);
    cs3 = 1'b1; oe3 = 1'b0; rw3 = 1'b1;
    stayed = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready3) stayed = 1'b0;
    end
    chk("abort_no_ready", {31'd0, stayed}, 32'd1);
    v = '{1'b1, 16'h0010, 1'b1, 8'h00, 1'b1, 8'h11};
    run_vec(100, v);

    // Full reset: DUT0 sweeps again, DUT3 keeps its contents.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_busy0", {31'd0, busy0}, 32'd1);
    chk("rst2_busy3", {31'd0, busy3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("sweep_len_final");
    v = '{1'b0, 16'h07FF, 1'b1, 8'h00, 1'b1, 8'h00};
    run_vec(101, v);
    v = '{1'b1, 16'h0010, 1'b1, 8'h00, 1'b1, 8'h11};
    run_vec(102, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_bus_ram.md
Name: nes_bus_ram

Overview:
- Parametrised, bus-attached synchronous RAM for the NES CPU/PPU address space. Successor to the flat 64K RAM.
- Adds address-region decode and power-of-two mirroring (default: 2 KB CPU work RAM mirrored across 0x0000–0x1FFF).
- Adds a programmable wait-state handshake with a `ready` strobe, and an optional memory-clear sweep after reset.
- Sits on the shared tristate data bus alongside other decoded slaves.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 16, bus address width.
- MEM_AW, 11, storage address width; depth = 2^MEM_AW words. Must satisfy MEM_AW <= REGION_AW.
- REGION_AW, 13, region size = 2^REGION_AW. Storage is mirrored 2^(REGION_AW-MEM_AW) times.
- BASE, 16'h0000, region base address. Only bits [ADDR_W-1:REGION_AW] are compared.
- WAIT_STATES, 0, extra cycles inserted before each access (0..15).
- CLEAR_ON_RESET, 1, when 1, sweep CLEAR_VALUE into all words after reset.
- CLEAR_VALUE, 8'h00, fill value for the sweep.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- addr  in  ADDR_W  bus address.
- data  inout  DATA_W  shared bidirectional data bus.
- rw_n  in  1  1 = read, 0 = write.
- cs_n  in  1  chip select, active-low.
- ready  out  1  access complete. High for exactly one cycle per access.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset: synchronous, active-low, on clock clk.
  - Sampled low at a posedge: ready=0, rdata register=0, wait counter=0.
  - State goes to CLEAR (busy=1, clear counter=0) if CLEAR_ON_RESET=1, else to IDLE (busy=0).
  - Memory contents are not otherwise altered by reset.
- Decode: hit = !cs_n && (addr[ADDR_W-1:REGION_AW] == BASE[ADDR_W-1:REGION_AW]). Word index = addr[MEM_AW-1:0].
- States: CLEAR, IDLE, WAIT, DONE.
- CLEAR:
  - Each cycle writes CLEAR_VALUE to mem[clr_cnt], then clr_cnt+1.
  - After the write of index 2^MEM_AW-1, go to IDLE and drop busy in the same edge. Sweep length is exactly 2^MEM_AW cycles.
  - Bus requests during CLEAR are ignored: no write, ready=0, data not driven.
  - Master must wait for busy=0.
- IDLE:
  - No hit: stay in IDLE.
  - Hit and WAIT_STATES=0: access at this edge, go to DONE.
  - Hit and WAIT_STATES>0: load wcnt=WAIT_STATES-1, go to WAIT.
- WAIT:
  - wcnt>0: decrement.
  - wcnt=0: access at this edge, go to DONE.
  - If hit drops while in WAIT: abort, return to IDLE, no access, ready stays 0.
- Access:
  - rw_n=0: mem[index] <= data.
  - rw_n=1: rdata <= mem[index].
  - addr, rw_n, cs_n and write data must be held stable from the request edge through the access edge.
- DONE: ready=1 for this single cycle; next edge always goes to IDLE.
  - Throughput: one access per WAIT_STATES+2 cycles.
  - Latency, request edge to ready high: WAIT_STATES+1 cycles.
- Bus drive: data = rdata only when state=DONE && hit && rw_n=1; otherwise high-Z. Other regions' cycles and writes are never driven.
- Mirroring: addresses differing only in bits [REGION_AW-1:MEM_AW] alias the same word.
- Reset mid-access: pending access is dropped (no write), ready=0. Reset mid-clear restarts the sweep at index 0.
- Simultaneous events:
  - The hit that ends a DONE cycle is not sampled. A held request restarts from IDLE on the following edge.
  - The rw_n value at the access edge decides the operation.

Test Plan:
- Reset with CLEAR_ON_RESET=1, MEM_AW=11 → busy=1 for exactly 2048 cycles. Then read 0x07FF → data=0x00, ready 1 cycle after request.
- WAIT_STATES=0: write 0x0123=0xA5, then read 0x0923 and 0x1923 (mirrors) → data=0xA5 during the ready cycle, high-Z otherwise.
- WAIT_STATES=3: read 0x0040 holding cs_n low → ready asserts 4 cycles after request edge. Continuously held request gives ready every 5 cycles.
- Out-of-region: cs_n=0, addr=0x2000, read and write 0x5A → ready never asserts, data stays high-Z, mem[0x000] unchanged.
- WAIT_STATES=3: deassert cs_n in the 2nd WAIT cycle of a write 0x0010=0x77 → no ready, later read of 0x0010 returns the prior value.
- Assert rst_n=0 mid-sweep at index 1000 → busy stays 1, sweep restarts at 0, busy drops 2048 cycles after reset release.
